// File: rtl/bcd_pkg.sv
// Shared types, constants and the BCD-to-segment lookup for the digit driver.
package bcd_pkg;

   typedef logic [6:0] seg_t;   // {g,f,e,d,c,b,a}

   localparam seg_t SEG_BLANK = 7'h00;
   localparam seg_t SEG_DASH  = 7'h40;

   localparam seg_t SEG_LUT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // Active-high pattern for a nibble; codes above 9 show a dash.
   function automatic seg_t bcd_to_seg(input logic [3:0] nibble);
      seg_t pat;
      if (nibble > 4'd9) pat = SEG_DASH;
      else               pat = SEG_LUT[nibble];
      return pat;
   endfunction

endpackage

// File: rtl/bcd_seven_seg_if.sv
// Load/data/status bundle between a BCD source and the digit driver.
interface bcd_seven_seg_if;
   import bcd_pkg::*;

   logic       load_syn;
   logic [3:0] Din;
   seg_t       seg;
   logic [3:0] digit_q;
   logic       err;
   logic       loaded;

   modport master (
      output load_syn, Din,
      input  seg, digit_q, err, loaded
   );

   modport slave (
      input  load_syn, Din,
      output seg, digit_q, err, loaded
   );
endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational nibble decode: active-high segment pattern plus illegal-code flag.
module bcd_seg_decode
   import bcd_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o,
   output logic       illegal_o
);

   assign seg_o     = bcd_to_seg(nibble_i);
   assign illegal_o = (nibble_i > 4'd9);

endmodule

// File: rtl/bcd_seven_seg.sv
// Single-digit BCD display driver: captures a nibble on load, holds it and
// drives registered segments with selectable polarity.
module bcd_seven_seg
   import bcd_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0
)(
   input  logic               clk,
   input  logic               rst_syn,
   bcd_seven_seg_if.slave     bus
);

   // XOR mask turns the active-high pattern into common-anode drive.
   localparam seg_t POL_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;

   seg_t       dec_seg;
   logic       dec_illegal;

   seg_t       seg_q,    seg_d;
   logic [3:0] digit_q,  digit_d;
   logic       err_q,    err_d;
   logic       loaded_q, loaded_d;

   bcd_seg_decode u_decode (
      .nibble_i  (bus.Din),
      .seg_o     (dec_seg),
      .illegal_o (dec_illegal)
   );

   // Next state: hold unless strobed; Din only matters on a load.
   always_comb begin
      seg_d    = seg_q;
      digit_d  = digit_q;
      err_d    = err_q;
      loaded_d = loaded_q;
      if (bus.load_syn) begin
         seg_d    = dec_seg ^ POL_MASK;
         digit_d  = bus.Din;
         err_d    = dec_illegal;
         loaded_d = 1'b1;
      end
   end

   // Output registers; reset wins over a simultaneous load.
   always_ff @(posedge clk) begin
      if (rst_syn) begin
         seg_q    <= SEG_BLANK ^ POL_MASK;
         digit_q  <= 4'd0;
         err_q    <= 1'b0;
         loaded_q <= 1'b0;
      end else begin
         seg_q    <= seg_d;
         digit_q  <= digit_d;
         err_q    <= err_d;
         loaded_q <= loaded_d;
      end
   end

   assign bus.seg     = seg_q;
   assign bus.digit_q = digit_q;
   assign bus.err     = err_q;
   assign bus.loaded  = loaded_q;

endmodule

// File: tb/tb_bcd_seven_seg.sv
// Directed bench for bcd_seven_seg: one active-high and one active-low instance.
module tb_bcd_seven_seg;

   logic clk;
   logic rst0, rst1;
   int   n_cmp;
   int   n_bad;

   bcd_seven_seg_if bus0 ();
   bcd_seven_seg_if bus1 ();

   bcd_seven_seg #(.ACTIVE_LOW(1'b0)) u_dut0 (
      .clk     (clk),
      .rst_syn (rst0),
      .bus     (bus0.slave)
   );

   bcd_seven_seg #(.ACTIVE_LOW(1'b1)) u_dut1 (
      .clk     (clk),
      .rst_syn (rst1),
      .bus     (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b1; bus0.load_syn = 1'b0; bus0.Din = 4'd0;
      tick(); tick();
      rst0 = 1'b0;
      n_cmp++; if (bus0.seg !== 7'h00) begin n_bad++; $display("FAIL reset_seg got %h exp %h", bus0.seg, 7'h00); end
      n_cmp++; if (bus0.digit_q !== 4'h0) begin n_bad++; $display("FAIL reset_digit got %h exp %h", bus0.digit_q, 4'h0); end
      n_cmp++; if (bus0.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp %b", bus0.err, 1'b0); end
      n_cmp++; if (bus0.loaded !== 1'b0) begin n_bad++; $display("FAIL reset_loaded got %b exp %b", bus0.loaded, 1'b0); end
   endtask

   task automatic test_load_hold();
      bus0.Din = 4'd5; bus0.load_syn = 1'b1;
      tick();
      bus0.load_syn = 1'b0; bus0.Din = 4'd3;
      n_cmp++; if (bus0.seg !== 7'h6D) begin n_bad++; $display("FAIL load5_seg got %h exp %h", bus0.seg, 7'h6D); end
      n_cmp++; if (bus0.digit_q !== 4'h5) begin n_bad++; $display("FAIL load5_digit got %h exp %h", bus0.digit_q, 4'h5); end
      n_cmp++; if (bus0.loaded !== 1'b1) begin n_bad++; $display("FAIL load5_loaded got %b exp %b", bus0.loaded, 1'b1); end
      n_cmp++; if (bus0.err !== 1'b0) begin n_bad++; $display("FAIL load5_err got %b exp %b", bus0.err, 1'b0); end
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (bus0.seg !== 7'h6D) begin n_bad++; $display("FAIL hold_seg got %h exp %h", bus0.seg, 7'h6D); end
      n_cmp++; if (bus0.digit_q !== 4'h5) begin n_bad++; $display("FAIL hold_digit got %h exp %h", bus0.digit_q, 4'h5); end
      n_cmp++; if (bus0.loaded !== 1'b1) begin n_bad++; $display("FAIL hold_loaded got %b exp %b", bus0.loaded, 1'b1); end
   endtask

   task automatic test_sweep();
      logic [6:0] exp_seg [10];
      exp_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      for (int i = 0; i < 10; i++) begin
         bus0.Din = 4'(i); bus0.load_syn = 1'b1;
         tick();
         n_cmp++; if (bus0.seg !== exp_seg[i]) begin n_bad++; $display("FAIL sweep_seg[%0d] got %h exp %h", i, bus0.seg, exp_seg[i]); end
         n_cmp++; if (bus0.digit_q !== 4'(i)) begin n_bad++; $display("FAIL sweep_digit[%0d] got %h exp %h", i, bus0.digit_q, 4'(i)); end
         n_cmp++; if (bus0.err !== 1'b0) begin n_bad++; $display("FAIL sweep_err[%0d] got %b exp %b", i, bus0.err, 1'b0); end
      end
      bus0.load_syn = 1'b0;
   endtask

   task automatic test_illegal();
      logic [3:0] codes [6];
      codes = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      bus0.Din = 4'hC; bus0.load_syn = 1'b1;
      tick();
      bus0.load_syn = 1'b0;
      n_cmp++; if (bus0.seg !== 7'h40) begin n_bad++; $display("FAIL ill12_seg got %h exp %h", bus0.seg, 7'h40); end
      n_cmp++; if (bus0.err !== 1'b1) begin n_bad++; $display("FAIL ill12_err got %b exp %b", bus0.err, 1'b1); end
      n_cmp++; if (bus0.digit_q !== 4'hC) begin n_bad++; $display("FAIL ill12_digit got %h exp %h", bus0.digit_q, 4'hC); end
      bus0.Din = 4'd7; bus0.load_syn = 1'b1;
      tick();
      bus0.load_syn = 1'b0;
      n_cmp++; if (bus0.seg !== 7'h07) begin n_bad++; $display("FAIL after_ill_seg got %h exp %h", bus0.seg, 7'h07); end
      n_cmp++; if (bus0.err !== 1'b0) begin n_bad++; $display("FAIL after_ill_err got %b exp %b", bus0.err, 1'b0); end
      for (int i = 0; i < 6; i++) begin
         bus0.Din = codes[i]; bus0.load_syn = 1'b1;
         tick();
         n_cmp++; if (bus0.seg !== 7'h40 || bus0.err !== 1'b1 || bus0.digit_q !== codes[i])
            begin n_bad++; $display("FAIL ill_code[%h] got seg %h err %b digit %h exp seg 40 err 1", codes[i], bus0.seg, bus0.err, bus0.digit_q); end
      end
      bus0.load_syn = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus0.Din = 4'd2; bus0.load_syn = 1'b1;
      tick();
      bus0.Din = 4'd2;
      tick();
      n_cmp++; if (bus0.seg !== 7'h5B || bus0.digit_q !== 4'd2) begin n_bad++; $display("FAIL reload_same got seg %h digit %h exp 5b 2", bus0.seg, bus0.digit_q); end
      bus0.Din = 4'd8;
      tick();
      bus0.load_syn = 1'b0;
      n_cmp++; if (bus0.seg !== 7'h7F || bus0.digit_q !== 4'd8) begin n_bad++; $display("FAIL b2b_8 got seg %h digit %h exp 7f 8", bus0.seg, bus0.digit_q); end
      bus0.Din = 4'hx;
      tick(); tick();
      n_cmp++; if (bus0.seg !== 7'h7F || bus0.digit_q !== 4'd8 || bus0.err !== 1'b0)
         begin n_bad++; $display("FAIL din_x_hold got seg %h digit %h err %b exp 7f 8 0", bus0.seg, bus0.digit_q, bus0.err); end
   endtask

   task automatic test_reset_load();
      rst0 = 1'b1; bus0.load_syn = 1'b1; bus0.Din = 4'd8;
      tick();
      rst0 = 1'b0; bus0.load_syn = 1'b0;
      n_cmp++; if (bus0.seg !== 7'h00) begin n_bad++; $display("FAIL rstld_seg got %h exp %h", bus0.seg, 7'h00); end
      n_cmp++; if (bus0.loaded !== 1'b0) begin n_bad++; $display("FAIL rstld_loaded got %b exp %b", bus0.loaded, 1'b0); end
      n_cmp++; if (bus0.digit_q !== 4'h0) begin n_bad++; $display("FAIL rstld_digit got %h exp %h", bus0.digit_q, 4'h0); end
      tick();
      n_cmp++; if (bus0.loaded !== 1'b0 || bus0.seg !== 7'h00) begin n_bad++; $display("FAIL rstld_after got seg %h loaded %b exp 00 0", bus0.seg, bus0.loaded); end
   endtask

   task automatic test_active_low();
      rst1 = 1'b1; bus1.load_syn = 1'b0; bus1.Din = 4'd0;
      tick(); tick();
      rst1 = 1'b0;
      n_cmp++; if (bus1.seg !== 7'h7F) begin n_bad++; $display("FAIL al_reset_seg got %h exp %h", bus1.seg, 7'h7F); end
      bus1.Din = 4'd5; bus1.load_syn = 1'b1;
      tick();
      n_cmp++; if (bus1.seg !== 7'h12) begin n_bad++; $display("FAIL al_load5_seg got %h exp %h", bus1.seg, 7'h12); end
      bus1.Din = 4'd15;
      tick();
      bus1.load_syn = 1'b0;
      n_cmp++; if (bus1.seg !== 7'h3F) begin n_bad++; $display("FAIL al_load15_seg got %h exp %h", bus1.seg, 7'h3F); end
      n_cmp++; if (bus1.err !== 1'b1 || bus1.digit_q !== 4'hF) begin n_bad++; $display("FAIL al_load15_flags got err %b digit %h exp 1 f", bus1.err, bus1.digit_q); end
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      n_cmp++; if (bus1.seg !== 7'h7F || bus1.loaded !== 1'b0 || bus1.err !== 1'b0)
         begin n_bad++; $display("FAIL al_midreset got seg %h loaded %b err %b exp 7f 0 0", bus1.seg, bus1.loaded, bus1.err); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst0 = 1'b1; rst1 = 1'b1;
      bus0.load_syn = 1'b0; bus0.Din = 4'd0;
      bus1.load_syn = 1'b0; bus1.Din = 4'd0;
      test_reset();
      test_load_hold();
      test_sweep();
      test_illegal();
      test_back_to_back();
      test_reset_load();
      test_active_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_seven_seg.md
Name: bcd_seven_seg

Overview:
- Single-digit BCD-to-seven-segment display driver.
- Captures a 4-bit BCD nibble on a load strobe, holds it, and drives a registered 7-segment pattern plus status flags.
- Sits between a BCD data source (counter/CPU register) and a physical LED digit.
- Segment polarity is selectable for common-cathode or common-anode parts.

Parameters:
- ACTIVE_LOW, 0, 1 = segment outputs inverted for common-anode digits; 0 = active-high segments.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_syn  input  1  synchronous, active-high reset.
- load_syn  input  1  synchronous load strobe; samples Din on the rising edge where it is 1.
- Din  input  4  BCD digit to capture; codes 10–15 are illegal.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, registered.
- digit_q  output  4  currently held nibble, raw, including illegal codes.
- err  output  1  1 while the held nibble is illegal (10–15).
- loaded  output  1  1 after the first load since reset.

Behaviour:
- Single clock domain. No combinational path from any input to any output.
- Reset:
  - Reset is sampled at the rising edge; rst_syn=1 overrides everything, including a simultaneous load.
  - Reset values: digit_q=0, err=0, loaded=0, seg=blank.
  - Blank is 7'h00 when ACTIVE_LOW=0 and 7'h7F when ACTIVE_LOW=1.
- Load:
  - At a rising edge with rst_syn=0 and load_syn=1: digit_q<=Din, loaded<=1, err<=(Din>9), seg<=pattern(Din).
  - All four outputs update on the same edge, i.e. one-cycle latency from the strobe to the display.
- Hold: with load_syn=0 and rst_syn=0, all outputs keep their values indefinitely.
- Back-to-back loads: a load on consecutive cycles updates every cycle. Reloading the same value produces no visible change.
- Active-high decode, before polarity inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - Illegal codes 10–15 show 7'h40 (segment g only, a dash) and set err=1.
- Polarity: when ACTIVE_LOW=1, seg is the bitwise inverse of the active-high pattern. This also applies to the reset blank.
- Reset mid-operation: a held digit is discarded at the reset edge. Display returns to blank and loaded=0 until the next load.
- Din is don't-care whenever load_syn=0. X on Din without a load must not propagate to the outputs.

Decomposition:
- Shared package bcd_pkg:
  - seg_t typedef (logic [6:0]).
  - SEG_BLANK and SEG_DASH constants.
  - A 10-entry constant array SEG_LUT of digit patterns.
  - A pure function bcd_to_seg(nibble) returning seg_t, which implements the dash for illegal codes.
- One natural sub-module: bcd_seg_decode.
  - Combinational, nibble in, active-high pattern and illegal flag out.
- The top holds the registers and applies ACTIVE_LOW inversion.

Test Plan:
- Reset with ACTIVE_LOW=0: hold rst_syn=1 for 2 cycles -> seg=00, digit_q=0, err=0, loaded=0.
- Load 5: after reset, Din=5, load_syn=1 for one cycle -> next edge seg=6D, digit_q=5, loaded=1, err=0. Values held 5 cycles later with Din changed to 3 and no load.
- Sweep: load 0..9 on consecutive cycles -> seg sequence 3F,06,5B,4F,66,6D,7D,07,7F,6F, each one cycle after its strobe, err=0 throughout.
- Illegal code: load 12 -> seg=40, err=1, digit_q=C. Then load 7 -> seg=07, err=0.
- Simultaneous reset and load: rst_syn=1, load_syn=1, Din=8 -> seg=00, loaded=0, digit_q=0.
- ACTIVE_LOW=1 instance: reset -> seg=7F; load 5 -> seg=12; load 15 -> seg=3F.
